seg7_capture: RTL and testbench



---
 rtl/seg7_pkg.sv | 51 +++++
 rtl/seg7_capture_if.sv | 33 +++
 rtl/seg7_encode.sv | 40 ++++
 rtl/seg7_capture.sv | 145 ++++++++++++++
 tb/tb_seg7_capture.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the 7-segment capture block.
//   - Segment bit indices (bit0=top ... bit6=middle, 1=lit).
//   - Pattern constants for digits 0..9, hex A..F and the blank pattern.
//   - Report record carried from the encoder to the output register.
//   - Output handshake FSM state type.
package seg7_pkg;

    localparam int SEG_W   = 7;
    localparam int DIGIT_W = 4;

    // Segment bit positions within a pattern.
    localparam int SEG_TOP = 0;
    localparam int SEG_UR  = 1;
    localparam int SEG_LR  = 2;
    localparam int SEG_BOT = 3;
    localparam int SEG_LL  = 4;
    localparam int SEG_UL  = 5;
    localparam int SEG_MID = 6;

    // Patterns are written MSB (middle) first.
    localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
    localparam logic [SEG_W-1:0] SEG_A     = 7'b1110111;
    localparam logic [SEG_W-1:0] SEG_B     = 7'b1111100;
    localparam logic [SEG_W-1:0] SEG_C     = 7'b0111001;
    localparam logic [SEG_W-1:0] SEG_D     = 7'b1011110;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_F     = 7'b1110001;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

    // One decoded report: digit is forced to 0 when blank or err is set.
    typedef struct packed {
        logic [DIGIT_W-1:0] digit;
        logic               blank;
        logic               err;
    } report_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/seg7_capture_if.sv
// seg7_capture_if: report handshake between seg7_capture and its consumer.
//   digit_out   : encoded digit (0 for blank/err reports)
//   blank_out   : report is the all-off pattern
//   err_out     : report is a pattern outside the encode table
//   valid_out   : the three fields above hold a report
//   ready_in    : consumer accepts the report this cycle
// modport master = producer (seg7_capture), modport slave = consumer.
interface seg7_capture_if;
    import seg7_pkg::*;

    logic [DIGIT_W-1:0] digit_out;
    logic               blank_out;
    logic               err_out;
    logic               valid_out;
    logic               ready_in;

    modport master (
        output digit_out,
        output blank_out,
        output err_out,
        output valid_out,
        input  ready_in
    );

    modport slave (
        input  digit_out,
        input  blank_out,
        input  err_out,
        input  valid_out,
        output ready_in
    );

endinterface

// File: rtl/seg7_encode.sv
// seg7_encode: combinational 7-segment pattern -> digit encoder.
//   seg : pattern, bit0=top ... bit6=middle, 1=lit
//   rpt : {digit, blank, err}
// Decimal patterns 0..9 always encode. With SEG7_CAPTURE_HEX_EN defined the
// hex patterns A,b,C,d,E,F encode to 10..15; otherwise they report err.
// The all-off pattern reports blank; anything else reports err.
module seg7_encode
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output report_t          rpt
);

    always_comb begin
        rpt = '0;
        case (seg)
            SEG_0:     rpt.digit = 4'd0;
            SEG_1:     rpt.digit = 4'd1;
            SEG_2:     rpt.digit = 4'd2;
            SEG_3:     rpt.digit = 4'd3;
            SEG_4:     rpt.digit = 4'd4;
            SEG_5:     rpt.digit = 4'd5;
            SEG_6:     rpt.digit = 4'd6;
            SEG_7:     rpt.digit = 4'd7;
            SEG_8:     rpt.digit = 4'd8;
            SEG_9:     rpt.digit = 4'd9;
`ifdef SEG7_CAPTURE_HEX_EN
            SEG_A:     rpt.digit = 4'd10;
            SEG_B:     rpt.digit = 4'd11;
            SEG_C:     rpt.digit = 4'd12;
            SEG_D:     rpt.digit = 4'd13;
            SEG_E:     rpt.digit = 4'd14;
            SEG_F:     rpt.digit = 4'd15;
`endif
            SEG_BLANK: rpt.blank = 1'b1;
            default:   rpt.err   = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// seg7_capture: samples an asynchronous 7-segment bus, filters transients and
// delivers each newly stable pattern once, encoded, over a valid/ready port.
//
// Parameters:
//   STABLE_CYCLES : cycles a synchronised pattern must hold (2..15)
//   CNT_W         : stability counter width, 2**CNT_W > STABLE_CYCLES
// Ports:
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   seg_in      : raw segment pattern, asynchronous to clk
//   clear_in    : synchronous clear of overrun_out (a same-cycle set wins)
//   overrun_out : sticky, a report was dropped while the consumer stalled
//   rpt_if      : report handshake (digit/blank/err/valid out, ready in)
// Optional feature: define SEG7_CAPTURE_HEX_EN to encode hex A..F.
//
// Latency: a pattern present before edge 0 shows valid_out after edge
// 2+STABLE_CYCLES (two sync flops, one candidate stage, counter ramp).
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 4
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEG_W-1:0] seg_in,
    input  logic             clear_in,
    output logic             overrun_out,
    seg7_capture_if.master   rpt_if
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(STABLE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Synchroniser and stability filter
    // ------------------------------------------------------------------
    logic [SEG_W-1:0] sync1_reg, sync2_reg;
    logic [SEG_W-1:0] cand_reg;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [SEG_W-1:0] last_reg;
    logic             accept;

    always_comb begin
        cnt_next = cnt_reg;
        if (sync2_reg != cand_reg) begin
            cnt_next = '0;
        end else if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // The counter saturates above CNT_HIT, so it sits on CNT_HIT for exactly
    // one cycle per stable run: that cycle is the accept pulse. Comparing
    // against last_reg suppresses re-reporting a pattern that came back.
    assign accept = (cnt_reg == CNT_HIT) && (cand_reg != last_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            cand_reg  <= '0;
            cnt_reg   <= '0;
            last_reg  <= SEG_BLANK;
        end else begin
            sync1_reg <= seg_in;
            sync2_reg <= sync1_reg;
            cand_reg  <= sync2_reg;
            cnt_reg   <= cnt_next;
            // Updated even when the report is dropped, so an overrun pattern
            // is not delivered later.
            if (accept) begin
                last_reg <= cand_reg;
            end
        end
    end

    // ------------------------------------------------------------------
    // Encoder
    // ------------------------------------------------------------------
    report_t new_rpt;

    seg7_encode u_encode (
        .seg (cand_reg),
        .rpt (new_rpt)
    );

    // ------------------------------------------------------------------
    // Output handshake FSM
    // ------------------------------------------------------------------
    out_state_t state_reg, state_next;
    report_t    rpt_reg, rpt_next;
    logic       ovr_reg, ovr_next;

    always_comb begin
        state_next = state_reg;
        rpt_next   = rpt_reg;
        ovr_next   = clear_in ? 1'b0 : ovr_reg;
        case (state_reg)
            ST_EMPTY: begin
                if (accept) begin
                    rpt_next   = new_rpt;
                    state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (rpt_if.ready_in) begin
                    // Consumer takes the held report; a simultaneous new
                    // report replaces it without loss.
                    if (accept) begin
                        rpt_next = new_rpt;
                    end else begin
                        state_next = ST_EMPTY;
                    end
                end else if (accept) begin
                    // Held report stays put; the new one is lost.
                    ovr_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_EMPTY;
            rpt_reg   <= '0;
            ovr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            rpt_reg   <= rpt_next;
            ovr_reg   <= ovr_next;
        end
    end

    assign rpt_if.valid_out = (state_reg == ST_FULL);
    assign rpt_if.digit_out = rpt_reg.digit;
    assign rpt_if.blank_out = rpt_reg.blank;
    assign rpt_if.err_out   = rpt_reg.err;
    assign overrun_out      = ovr_reg;

endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed, table-driven bench for seg7_capture
// (default STABLE_CYCLES=4). Expected values for hex patterns follow
// SEG7_CAPTURE_HEX_EN.
module tb_seg7_capture;
    import seg7_pkg::*;

`ifdef SEG7_CAPTURE_HEX_EN
    localparam int HEX = 1;
`else
    localparam int HEX = 0;
`endif

    logic             clk;
    logic             rst_n;
    logic [SEG_W-1:0] seg_in;
    logic             clear_in;
    logic             overrun_out;

    seg7_capture_if rpt_if ();

    seg7_capture #(
        .STABLE_CYCLES (4),
        .CNT_W         (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .clear_in    (clear_in),
        .overrun_out (overrun_out),
        .rpt_if      (rpt_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Handshake collector: counts accepted reports and keeps the last one.
    int rpt_cnt = 0;
    int last_digit = 0;
    int last_blank = 0;
    int last_err = 0;

    always @(negedge clk) begin
        if (rst_n && rpt_if.valid_out && rpt_if.ready_in) begin
            rpt_cnt    = rpt_cnt + 1;
            last_digit = int'(rpt_if.digit_out);
            last_blank = int'(rpt_if.blank_out);
            last_err   = int'(rpt_if.err_out);
            $display("report: digit=%0d blank=%0d err=%0d", last_digit, last_blank, last_err);
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks = n_checks + 1;
        if (actual != expected) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [6:0] seg;
        int         hold;
        int         exp_cnt;
        int         exp_digit;
        int         exp_blank;
        int         exp_err;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int first_edge;
        int vcnt;
        int vdigit;

        vecs[0]  = '{7'b0111111, 10, 1, 0, 0, 0};
        vecs[1]  = '{7'b0000110, 10, 1, 1, 0, 0};
        vecs[2]  = '{7'b1001111, 10, 1, 3, 0, 0};
        vecs[3]  = '{7'b1100110, 10, 1, 4, 0, 0};
        vecs[4]  = '{7'b1101101, 10, 1, 5, 0, 0};
        vecs[5]  = '{7'b0000000, 10, 1, 0, 1, 0};
        vecs[6]  = '{7'b0000000, 10, 0, 0, 0, 0};
        vecs[7]  = '{7'b1111101, 10, 1, 6, 0, 0};
        vecs[8]  = '{7'b0000111, 10, 1, 7, 0, 0};
        vecs[9]  = '{7'b1111111, 10, 1, 8, 0, 0};
        vecs[10] = '{7'b1101111, 10, 1, 9, 0, 0};
        vecs[11] = '{7'b1110111, 10, 1, (HEX != 0) ? 10 : 0, 0, (HEX != 0) ? 0 : 1};
        vecs[12] = '{7'b1111100, 10, 1, (HEX != 0) ? 11 : 0, 0, (HEX != 0) ? 0 : 1};
        vecs[13] = '{7'b0001001, 10, 1, 0, 0, 1};
        vecs[14] = '{7'b1111001, 10, 1, (HEX != 0) ? 14 : 0, 0, (HEX != 0) ? 0 : 1};

        // ---------------- reset state and first-report latency -----------
        rst_n           = 1'b0;
        seg_in          = 7'b1011011;
        clear_in        = 1'b0;
        rpt_if.ready_in = 1'b1;
        cycles(3);
        check("reset_valid", int'(rpt_if.valid_out), 0);
        check("reset_digit", int'(rpt_if.digit_out), 0);
        check("reset_blank", int'(rpt_if.blank_out), 0);
        check("reset_err", int'(rpt_if.err_out), 0);
        check("reset_overrun", int'(overrun_out), 0);

        rst_n      = 1'b1;   // next rising edge is edge 0
        first_edge = 0;
        vcnt       = 0;
        vdigit     = -1;
        for (int e = 0; e <= 10; e++) begin
            @(posedge clk);
            #1;
            if (rpt_if.valid_out) begin
                if (first_edge == 0) begin
                    first_edge = e;
                    vdigit     = int'(rpt_if.digit_out);
                    check("first_err", int'(rpt_if.err_out), 0);
                    check("first_blank", int'(rpt_if.blank_out), 0);
                end
                vcnt = vcnt + 1;
            end
        end
        check("first_latency_edge", first_edge, 6);
        check("first_valid_cycles", vcnt, 1);
        check("first_digit", vdigit, 2);

        // ---------------- table of patterns, consumer always ready -------
        for (int i = 0; i < 15; i++) begin
            rpt_cnt = 0;
            seg_in  = vecs[i].seg;
            cycles(vecs[i].hold);
            $display("vector %0d: seg=%b reports=%0d", i, vecs[i].seg, rpt_cnt);
            check($sformatf("vec%0d_count", i), rpt_cnt, vecs[i].exp_cnt);
            if (vecs[i].exp_cnt == 1) begin
                check($sformatf("vec%0d_digit", i), last_digit, vecs[i].exp_digit);
                check($sformatf("vec%0d_blank", i), last_blank, vecs[i].exp_blank);
                check($sformatf("vec%0d_err", i), last_err, vecs[i].exp_err);
            end
        end

        // ---------------- short glitch produces no report -----------------
        rpt_cnt = 0;
        seg_in  = 7'b1111111;
        cycles(3);
        seg_in  = vecs[14].seg;
        cycles(12);
        check("glitch_no_report", rpt_cnt, 0);

        // ---------------- overrun with stalled consumer ------------------
        rpt_if.ready_in = 1'b0;
        rpt_cnt         = 0;
        seg_in          = 7'b0000110;
        cycles(10);
        check("stall_valid", int'(rpt_if.valid_out), 1);
        check("stall_digit", int'(rpt_if.digit_out), 1);
        check("stall_overrun_clear", int'(overrun_out), 0);
        seg_in = 7'b1001111;
        cycles(10);
        check("ovr_valid_held", int'(rpt_if.valid_out), 1);
        check("ovr_digit_held", int'(rpt_if.digit_out), 1);
        check("ovr_set", int'(overrun_out), 1);
        clear_in = 1'b1;
        cycles(1);
        clear_in = 1'b0;
        check("ovr_cleared", int'(overrun_out), 0);
        check("ovr_valid_after_clear", int'(rpt_if.valid_out), 1);
        rpt_if.ready_in = 1'b1;
        cycles(12);
        check("drain_count", rpt_cnt, 1);
        check("drain_digit", last_digit, 1);
        check("drain_valid_low", int'(rpt_if.valid_out), 0);

        // ---------------- asynchronous reset mid-operation ---------------
        rpt_if.ready_in = 1'b0;
        seg_in          = 7'b1101101;
        cycles(10);
        check("pre_rst_digit", int'(rpt_if.digit_out), 5);
        seg_in = 7'b0000000;
        cycles(10);
        seg_in = 7'b1101101;
        cycles(10);
        check("pre_rst_overrun", int'(overrun_out), 1);
        check("pre_rst_valid", int'(rpt_if.valid_out), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", int'(rpt_if.valid_out), 0);
        check("async_rst_digit", int'(rpt_if.digit_out), 0);
        check("async_rst_overrun", int'(overrun_out), 0);
        cycles(1);
        rpt_cnt         = 0;
        rpt_if.ready_in = 1'b1;
        rst_n           = 1'b1;
        cycles(14);
        check("post_rst_count", rpt_cnt, 1);
        check("post_rst_digit", last_digit, 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
